led_scan_driver: RTL and testbench
==================================

LED_SCAN_DRIVER -- requirements
Module: led_scan_driver

Interface
REQ-001 Parameter TICK_DIV, default 4, clk cycles per PWM step; legal range is 1 to 255.
REQ-002 Parameter BLANK_CYCLES, default 8, number of all-off cycles between rows; legal range is 1 to 255.
REQ-003 Parameter BRIGHT_INIT, default 8'h80, brightness used after reset.
REQ-004 clk  in  1  system clock; all logic is rising-edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 row_data  in  8  pixel byte for row_idx; registered source, valid one cycle after row_idx changes.
REQ-007 row_idx  out  3  row currently requested from the frame store.
REQ-008 brightness_valid  in  1  single-cycle strobe qualifying brightness.
REQ-009 brightness  in  8  new brightness value; 0 means off, 255 means maximum.
REQ-010 row_sel  out  8  row enables, active-low, one-hot-zero; bit n drives row n.
REQ-011 col_out  out  8  column drive, active-high; bit n drives column n.
REQ-012 frame_start  out  1  one-cycle pulse marking the start of row 0 of each frame.

Function
REQ-013 The block SHALL implement the states FETCH, LATCH, DISPLAY, BLANK and NEXT, with all outputs registered.
REQ-014 FETCH: hold row_idx for 1 cycle so the frame store can produce data, then go to LATCH.
REQ-015 LATCH: capture row_data into row_reg, clear pwm_cnt and div_cnt, then go to DISPLAY.
REQ-016 DISPLAY: div_cnt counts 0 to TICK_DIV-1; on wrap, pwm_cnt increments; after pwm_cnt wraps 255 to 0, go to BLANK.
REQ-017 DISPLAY outputs: row_sel = ~(8'b1 << row_idx); col_out = row_reg when pwm_cnt < bright_act, else 8'h00.
REQ-018 DISPLAY SHALL last exactly 256*TICK_DIV cycles, so the on-time per row is bright_act*TICK_DIV cycles.
REQ-019 BLANK: row_sel = 8'hFF and col_out = 8'h00 for exactly BLANK_CYCLES cycles, then go to NEXT.
REQ-020 NEXT: row_idx increments modulo 8 (7 wraps to 0), then go to FETCH; row_sel and col_out stay blanked.
REQ-021 In every non-DISPLAY state, row_sel SHALL be 8'hFF and col_out SHALL be 8'h00.
REQ-022 Row period SHALL be 2 + 256*TICK_DIV + BLANK_CYCLES + 1 cycles, i.e. 1035 cycles at default parameters.
REQ-023 brightness_valid=1 SHALL load brightness into bright_pend; the last strobe before the frame boundary wins.
REQ-024 bright_act SHALL load from bright_pend only on the NEXT-to-FETCH transition where row_idx becomes 0, so there is no tearing mid-frame.
REQ-025 A strobe in the same cycle as that transition SHALL update bright_pend only, and takes effect at the following frame.
REQ-026 frame_start SHALL be 1 during the cycle the FSM is in FETCH with row_idx=0, and 0 otherwise.
REQ-027 bright_act=0 SHALL give col_out=8'h00 for the whole frame; row_sel still scans.
REQ-028 row_data SHALL be sampled only in LATCH; changes at other times SHALL have no effect until the next row.

Reset
REQ-029 On rst_n=0, immediately: row_sel=8'hFF, col_out=8'h00, frame_start=0, row_idx=0.
REQ-030 On rst_n=0, also: state=FETCH, row_reg=0, pwm_cnt=0, div_cnt=0, bright_pend=bright_act=BRIGHT_INIT.
REQ-031 Reset asserted mid-DISPLAY SHALL blank outputs asynchronously, within the same cycle.
REQ-032 After reset release, the first FETCH is for row 0 and frame_start pulses on the first clock edge.

Verification
REQ-033 Reset check: assert rst_n=0 mid-DISPLAY -> row_sel=8'hFF and col_out=0 without a clock edge; on release, frame_start pulses and row_idx=0.
REQ-034 Scan order: default parameters, model frame store returns 8'h10+row -> row_sel walks FE,FD,...,7F and wraps to FE; each row is active 1024 cycles; frame_start every 8280 cycles.
REQ-035 Duty: TICK_DIV=1, brightness 8'h40, row_data 8'hA5 -> col_out=8'hA5 for 64 cycles, then 8'h00 for 192 cycles, per row.
REQ-036 Deferred brightness: strobe 8'hFF while row 3 is displayed -> rows 3 to 7 keep the old duty; row 0 of the next frame shows 255/256 duty.
REQ-037 Boundary strobe: strobe 8'h00 in the cycle row_idx becomes 0 -> the current frame keeps its duty; the next frame has col_out=0 throughout.
REQ-038 Data isolation: change row_data during DISPLAY -> col_out keeps the value latched in LATCH until the next row.

Source files
------------

// File: rtl/led_scan_driver.sv
// led_scan_driver: row-scanned 8x8 LED driver with per-row PWM brightness and frame-synchronous brightness update.
module led_scan_driver #(
    parameter int          TICK_DIV     = 4,
    parameter int          BLANK_CYCLES = 8,
    parameter logic [7:0]  BRIGHT_INIT  = 8'h80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] row_data,
    output logic [2:0] row_idx,
    input  logic       brightness_valid,
    input  logic [7:0] brightness,
    output logic [7:0] row_sel,
    output logic [7:0] col_out,
    output logic       frame_start
);
    typedef enum logic [2:0] {FETCH, LATCH, DISPLAY, BLANK, NEXT} state_t;
    localparam logic [7:0] DIV_LAST   = 8'(TICK_DIV - 1);
    localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);
    state_t     state, state_n;
    logic       started;
    logic [2:0] idx_n;
    logic [7:0] row_reg, row_reg_n, pwm_cnt, pwm_n, div_cnt, div_n;
    logic [7:0] bright_pend, bright_pend_n, bright_act, bright_act_n;
    logic [7:0] row_sel_n, col_n;
    logic       fs_n, disp_n;
    always_comb begin
        state_n       = state;
        idx_n         = row_idx;
        row_reg_n     = row_reg;
        pwm_n         = pwm_cnt;
        div_n         = div_cnt;
        bright_pend_n = brightness_valid ? brightness : bright_pend;
        bright_act_n  = bright_act;
        case (state)
            // the first FETCH after reset is held one edge so frame_start can pulse
            FETCH:   state_n = started ? LATCH : FETCH;
            LATCH: begin
                row_reg_n = row_data;
                pwm_n     = 8'd0;
                div_n     = 8'd0;
                state_n   = DISPLAY;
            end
            DISPLAY: begin
                div_n   = (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
                pwm_n   = (div_cnt == DIV_LAST) ? pwm_cnt + 8'd1 : pwm_cnt;
                state_n = (div_cnt == DIV_LAST && pwm_cnt == 8'hFF) ? BLANK : DISPLAY;
            end
            BLANK: begin
                div_n   = (div_cnt == BLANK_LAST) ? 8'd0 : div_cnt + 8'd1;
                state_n = (div_cnt == BLANK_LAST) ? NEXT : BLANK;
            end
            NEXT: begin
                idx_n        = row_idx + 3'd1;
                bright_act_n = (row_idx == 3'd7) ? bright_pend : bright_act;
                state_n      = FETCH;
            end
            default: state_n = FETCH;
        endcase
        disp_n    = (state_n == DISPLAY);
        row_sel_n = disp_n ? ~(8'b1 << idx_n) : 8'hFF;
        col_n     = (disp_n && pwm_n < bright_act_n) ? row_reg_n : 8'h00;
        fs_n      = (state_n == FETCH) && (idx_n == 3'd0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            started     <= 1'b0;
            row_idx     <= 3'd0;
            row_reg     <= 8'd0;
            pwm_cnt     <= 8'd0;
            div_cnt     <= 8'd0;
            bright_pend <= BRIGHT_INIT;
            bright_act  <= BRIGHT_INIT;
            row_sel     <= 8'hFF;
            col_out     <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            started     <= 1'b1;
            row_idx     <= idx_n;
            row_reg     <= row_reg_n;
            pwm_cnt     <= pwm_n;
            div_cnt     <= div_n;
            bright_pend <= bright_pend_n;
            bright_act  <= bright_act_n;
            row_sel     <= row_sel_n;
            col_out     <= col_n;
            frame_start <= fs_n;
        end
    end
endmodule

// File: tb/tb_led_scan_driver.sv
// tb_led_scan_driver: directed checks of scan order, PWM duty, deferred brightness, data isolation and async reset.
module tb_led_scan_driver;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d_row_data, d_row_sel, d_col_out;
    logic [2:0] d_row_idx;
    logic       d_frame_start;
    logic [7:0] f_row_data, f_row_sel, f_col_out;
    logic [2:0] f_row_idx;
    logic       f_frame_start;
    logic       fb_v;
    logic [7:0] fb;
    logic [7:0] mem_f [8];
    int         total = 0, bad = 0, cyc = 0, fs_n = 0, fs_last = 0, fs_prev = 0;
    logic [7:0] sel, col, exp_sel;
    int         on, off;

    always #5 clk = ~clk;

    led_scan_driver u_def (
        .clk(clk), .rst_n(rst_n), .row_data(d_row_data), .row_idx(d_row_idx),
        .brightness_valid(1'b0), .brightness(8'h00),
        .row_sel(d_row_sel), .col_out(d_col_out), .frame_start(d_frame_start)
    );

    led_scan_driver #(.TICK_DIV(1), .BLANK_CYCLES(2)) u_fast (
        .clk(clk), .rst_n(rst_n), .row_data(f_row_data), .row_idx(f_row_idx),
        .brightness_valid(fb_v), .brightness(fb),
        .row_sel(f_row_sel), .col_out(f_col_out), .frame_start(f_frame_start)
    );

    // registered frame stores, one cycle behind row_idx
    always @(posedge clk) begin
        d_row_data <= 8'h10 + {5'd0, d_row_idx};
        f_row_data <= mem_f[f_row_idx];
        cyc        <= cyc + 1;
    end

    always @(negedge clk) if (d_frame_start) begin
        fs_prev = fs_last;
        fs_last = cyc;
        fs_n++;
    end

    function automatic logic [7:0] cur_sel(input bit fast);
        return fast ? f_row_sel : d_row_sel;
    endfunction

    function automatic logic [7:0] cur_col(input bit fast);
        return fast ? f_col_out : d_col_out;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s: observed=timeout expected=event", tag);
    endtask

    task automatic wait_sel(input bit fast, input logic [7:0] v);
        int n = 0;
        while (cur_sel(fast) !== v && n < 9000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 9000) timeout("wait_sel");
    endtask

    task automatic wait_fs_fast();
        int n = 0;
        while (f_frame_start !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) timeout("wait_fs");
    endtask

    // one display window: on = cycles with lit columns, off = dark cycles
    task automatic measure(input bit fast, output logic [7:0] s, output logic [7:0] c,
                           output int n_on, output int n_off);
        int n = 0;
        n_on = 0;
        n_off = 0;
        c = 8'h00;
        while (cur_sel(fast) === 8'hFF && n < 1200) begin
            @(negedge clk);
            n++;
        end
        s = cur_sel(fast);
        while (cur_sel(fast) !== 8'hFF && n < 2500) begin
            if (cur_col(fast) !== 8'h00) begin
                n_on++;
                c = cur_col(fast);
            end else n_off++;
            @(negedge clk);
            n++;
        end
        if (n >= 2500) timeout("measure");
    endtask

    task automatic strobe(input logic [7:0] v);
        fb_v = 1'b1;
        fb = v;
        @(negedge clk);
        fb_v = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        fb_v = 1'b0;
        fb = 8'h00;
        for (int i = 0; i < 8; i++) mem_f[i] = 8'hA5;
        repeat (3) @(negedge clk);
        chk("rst_sel", d_row_sel, 8'hFF);
        chk("rst_col", d_col_out, 8'h00);
        chk("rst_fs", d_frame_start, 1'b0);
        chk("rst_idx", d_row_idx, 3'd0);
        chk("rst_sel_fast", f_row_sel, 8'hFF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_fs", d_frame_start, 1'b1);
        chk("rel_idx", d_row_idx, 3'd0);
        chk("rel_fs_fast", f_frame_start, 1'b1);
        @(negedge clk);
        chk("fs_one_cycle", d_frame_start, 1'b0);
        // default parameters: 9 rows, wrapping back to row 0
        for (int r = 0; r < 9; r++) begin
            measure(1'b0, sel, col, on, off);
            exp_sel = ~(8'h01 << r[2:0]);
            chk($sformatf("scan_sel_r%0d", r), sel, exp_sel);
            chk($sformatf("scan_len_r%0d", r), on + off, 1024);
            chk($sformatf("scan_on_r%0d", r), on, 512);
            chk($sformatf("scan_col_r%0d", r), col, 8'h10 + 8'(r[2:0]));
        end
        chk("frame_period", (fs_n >= 2) ? fs_last - fs_prev : 0, 8280);
        // duty at TICK_DIV=1
        wait_sel(1'b1, 8'hFE);
        strobe(8'h40);
        wait_fs_fast();
        measure(1'b1, sel, col, on, off);
        chk("duty_sel", sel, 8'hFE);
        chk("duty_on", on, 64);
        chk("duty_off", off, 192);
        chk("duty_col", col, 8'hA5);
        // row_data changes mid-row must not reach col_out
        wait_sel(1'b1, 8'hFD);
        mem_f[1] = 8'h3C;
        repeat (5) @(negedge clk);
        chk("iso_early", f_col_out, 8'hA5);
        repeat (40) @(negedge clk);
        chk("iso_late", f_col_out, 8'hA5);
        mem_f[1] = 8'hA5;
        // strobe during row 3 waits for the next frame
        wait_sel(1'b1, 8'hF7);
        strobe(8'hFF);
        wait_sel(1'b1, 8'hFF);
        for (int r = 4; r < 8; r++) begin
            measure(1'b1, sel, col, on, off);
            exp_sel = ~(8'h01 << r[2:0]);
            chk($sformatf("def_sel_r%0d", r), sel, exp_sel);
            chk($sformatf("def_on_r%0d", r), on, 64);
        end
        measure(1'b1, sel, col, on, off);
        chk("def_new_sel", sel, 8'hFE);
        chk("def_new_on", on, 255);
        chk("def_new_off", off, 1);
        // strobe coinciding with the frame boundary
        wait_sel(1'b1, 8'h7F);
        wait_sel(1'b1, 8'hFF);
        repeat (2) @(negedge clk);
        chk("bnd_next_idx", f_row_idx, 3'd7);
        fb_v = 1'b1;
        fb = 8'h00;
        @(negedge clk);
        fb_v = 1'b0;
        chk("bnd_fs", f_frame_start, 1'b1);
        chk("bnd_idx", f_row_idx, 3'd0);
        measure(1'b1, sel, col, on, off);
        chk("bnd_keep_on", on, 255);
        wait_fs_fast();
        measure(1'b1, sel, col, on, off);
        chk("bnd_zero_sel", sel, 8'hFE);
        chk("bnd_zero_on", on, 0);
        chk("bnd_zero_off", off, 256);
        // asynchronous reset in the middle of a lit display row
        wait_sel(1'b0, 8'hFE);
        chk("pre_rst_col", d_col_out, 8'h10);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_sel", d_row_sel, 8'hFF);
        chk("arst_col", d_col_out, 8'h00);
        chk("arst_idx", d_row_idx, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arel_fs", d_frame_start, 1'b1);
        chk("arel_idx", d_row_idx, 3'd0);
        chk("arel_sel", d_row_sel, 8'hFF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
